hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline control counterpart to the forwarding unit. Forwarding bypasses results forward; this block holds back and kills instructions when bypassing cannot resolve a hazard.
- Detects load-use hazards and taken-branch redirects. Freezes the pipeline on multi-cycle data-memory accesses.
- Drives the stall and flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Sits beside the forwarding unit in the core top level and keeps performance and error status.

Parameters:
REDIRECT_EXTRA, 0, additional cycles FlushD is held after a taken branch (instruction-memory latency beyond 1), range 0..7
MEM_TIMEOUT, 255, maximum consecutive MEM_WAIT cycles before MemErr is raised
CNT_W, 32, width of performance counters

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-high reset
MemReadE  input  1  instruction in EX is a load
RD_E  input  5  destination register of the EX instruction
Rs1_D  input  5  source register 1 of the ID instruction
Rs2_D  input  5  source register 2 of the ID instruction
UsesRs1D  input  1  ID instruction reads Rs1
UsesRs2D  input  1  ID instruction reads Rs2
PCSrcE  input  1  branch/jump taken, resolved in EX
MemReqM  input  1  MEM-stage instruction accesses data memory
MemReadyM  input  1  data memory completes access this cycle
StallF  output  1  hold PC
StallD  output  1  hold IF/ID
StallE  output  1  hold ID/EX
StallM  output  1  hold EX/MEM
FlushD  output  1  clear IF/ID
FlushE  output  1  clear ID/EX
FlushW  output  1  clear MEM/WB (insert bubble)
MemErr  output  1  sticky memory-timeout flag
StallCycles  output  CNT_W  count of cycles with StallF=1
FlushCount  output  CNT_W  count of taken-branch redirects

Behaviour:
- Reset (async, rst=1):
  - state=RUN; redirect counter, timeout counter, StallCycles, FlushCount all 0; MemErr=0.
  - All control outputs forced 0 while rst=1.
- Control outputs are combinational from state and inputs. State and counters update on the rising clk edge.
- lwHaz = MemReadE & (RD_E!=0) & ((UsesRs1D & Rs1_D==RD_E) | (UsesRs2D & Rs2_D==RD_E)).
- memBusy = MemReqM & ~MemReadyM.
- FSM states: RUN, MEM_WAIT, REDIRECT.
- Priority within any cycle: memBusy > PCSrcE > lwHaz.
- memBusy (RUN, REDIRECT or MEM_WAIT):
  - StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
  - Next state MEM_WAIT.
  - PCSrcE and lwHaz are ignored (EX is frozen and re-presents them later).
  - Pending REDIRECT count is preserved and resumes after the wait.
- MEM_WAIT with MemReadyM=1:
  - Stalls released; cycle evaluated with RUN rules.
  - Next state RUN, or REDIRECT if a redirect count remains.
- Timeout counter:
  - Increments each memBusy cycle; clears on any cycle without memBusy.
  - Reaching MEM_TIMEOUT sets MemErr=1. MemErr clears only on rst.
  - Stalling continues after MemErr is set.
- PCSrcE (no memBusy):
  - FlushD=1, FlushE=1, no stalls.
  - FlushCount increments (saturating).
  - If REDIRECT_EXTRA>0: load the redirect counter with REDIRECT_EXTRA and go to REDIRECT.
- REDIRECT (no memBusy):
  - FlushD=1; counter decrements; return to RUN when it reaches 0.
  - lwHaz is ignored, because the ID instruction is being flushed.
  - A new PCSrcE reloads the counter and asserts FlushE.
- lwHaz (RUN, no PCSrcE): StallF=StallD=1, FlushE=1, for exactly one cycle. The load advances to MEM, so lwHaz self-clears.
- PCSrcE together with lwHaz: the flush rule wins; no StallF/StallD.
- StallCycles: increments every cycle StallF=1; saturates at all-ones. FlushCount saturates likewise.
- RD_E=0 never produces a load-use stall.

Test Plan:
- Load x5 in EX (MemReadE=1, RD_E=5), ID Rs2_D=5, UsesRs2D=1 -> one cycle StallF=StallD=FlushE=1; next cycle (MemReadE=0) all 0; StallCycles=1.
- Same with RD_E=0, or UsesRs2D=0 -> no stall; outputs all 0.
- PCSrcE=1 with lwHaz=1 and REDIRECT_EXTRA=2 -> FlushD=FlushE=1, StallF=0; FlushD held 2 further cycles; FlushCount=1.
- MemReqM=1, MemReadyM=0 for 4 cycles then 1 -> StallF/D/E/M and FlushW high 4 cycles, released on the ready cycle; StallCycles=4; a PCSrcE held during the wait is acted on only at the ready cycle.
- MEM_TIMEOUT=8, MemReadyM held 0 -> MemErr rises after 8 busy cycles and stays 1 after ready; rst pulse mid-wait -> all outputs 0 immediately, counters 0, state RUN.
- Force StallF high 2^CNT_W+3 cycles with CNT_W=4 -> StallCycles stops at 15.

Source files
------------

// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller: load-use stalls, taken-branch flushes and
// data-memory wait freezes, plus stall/flush counters and a sticky timeout flag.
module hazard_stall_unit #(
  parameter int REDIRECT_EXTRA = 0,
  parameter int MEM_TIMEOUT    = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemReadE,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic             UsesRs1D,
  input  logic             UsesRs2D,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCycles,
  output logic [CNT_W-1:0] FlushCount
);

  typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;

  localparam int            TW   = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(MEM_TIMEOUT);
  localparam logic [2:0]    RX   = 3'(REDIRECT_EXTRA);

  state_t           state_q, state_d;
  logic [2:0]       rcnt_q, rcnt_d;
  logic [TW-1:0]    tcnt_q, tcnt_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_inc;
  logic             lw_haz, mem_busy;

  assign lw_haz   = MemReadE && (RD_E != 5'd0) &&
                    ((UsesRs1D && (Rs1_D == RD_E)) || (UsesRs2D && (Rs2_D == RD_E)));
  assign mem_busy = MemReqM && !MemReadyM;

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    flush_inc = 1'b0;
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    tcnt_d    = '0;
    err_d     = err_q;

    if (mem_busy) begin
      // EX is frozen, so branch/load-use decisions wait; redirect count is kept
      StallF  = 1'b1;
      StallD  = 1'b1;
      StallE  = 1'b1;
      StallM  = 1'b1;
      FlushW  = 1'b1;
      state_d = MEM_WAIT;
      tcnt_d  = (tcnt_q == TMAX) ? tcnt_q : tcnt_q + TW'(1);
      if (tcnt_d == TMAX) err_d = 1'b1;
    end else if (state_q == REDIRECT) begin
      FlushD = 1'b1;
      if (PCSrcE) begin
        FlushE    = 1'b1;
        flush_inc = 1'b1;
        rcnt_d    = RX;
        state_d   = (RX != 3'd0) ? REDIRECT : RUN;
      end else begin
        rcnt_d  = (rcnt_q != 3'd0) ? rcnt_q - 3'd1 : 3'd0;
        if (rcnt_q <= 3'd1) state_d = RUN;
      end
    end else begin
      // RUN, or the release cycle of MEM_WAIT: a leftover redirect resumes next
      state_d = (rcnt_q != 3'd0) ? REDIRECT : RUN;
      if (PCSrcE) begin
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        flush_inc = 1'b1;
        if (RX != 3'd0) begin
          rcnt_d  = RX;
          state_d = REDIRECT;
        end
      end else if (lw_haz) begin
        StallF = 1'b1;
        StallD = 1'b1;
        FlushE = 1'b1;
      end
    end

    if (rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      flush_inc = 1'b0;
    end

    stall_cnt_d = (StallF && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
    flush_cnt_d = (flush_inc && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      rcnt_q      <= '0;
      tcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      rcnt_q      <= rcnt_d;
      tcnt_q      <= tcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr      = err_q;
  assign StallCycles = stall_cnt_q;
  assign FlushCount  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit with REDIRECT_EXTRA=2, MEM_TIMEOUT=8, CNT_W=4.
module tb_hazard_stall_unit;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic MemReadE, UsesRs1D, UsesRs2D, PCSrcE, MemReqM, MemReadyM;
  logic [4:0] RD_E, Rs1_D, Rs2_D;
  logic StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr;
  logic [CNT_W-1:0] StallCycles, FlushCount;

  int n_chk  = 0;
  int n_fail = 0;

  // control vector order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  localparam logic [6:0] C_IDLE  = 7'b0000000;
  localparam logic [6:0] C_LWS   = 7'b1100010;
  localparam logic [6:0] C_BR    = 7'b0000110;
  localparam logic [6:0] C_RDR   = 7'b0000100;
  localparam logic [6:0] C_MEMW  = 7'b1111001;

  hazard_stall_unit #(.REDIRECT_EXTRA(2), .MEM_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .MemReadE(MemReadE), .RD_E(RD_E), .Rs1_D(Rs1_D),
    .Rs2_D(Rs2_D), .UsesRs1D(UsesRs1D), .UsesRs2D(UsesRs2D), .PCSrcE(PCSrcE),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM), .StallF(StallF), .StallD(StallD),
    .StallE(StallE), .StallM(StallM), .FlushD(FlushD), .FlushE(FlushE),
    .FlushW(FlushW), .MemErr(MemErr), .StallCycles(StallCycles), .FlushCount(FlushCount)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ctl();
    return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    MemReadE = 0; UsesRs1D = 0; UsesRs2D = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    RD_E = 0; Rs1_D = 0; Rs2_D = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic set_lw(input logic [4:0] rd, input logic [4:0] r2, input logic u2);
    MemReadE = 1; RD_E = rd; Rs2_D = r2; UsesRs2D = u2;
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    // outputs forced low under reset even with a live hazard
    set_lw(5'd5, 5'd5, 1'b1);
    PCSrcE = 1;
    #2;
    chk("rst_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("rst_err", 32'(MemErr), 0);
    chk("rst_stallcnt", 32'(StallCycles), 0);
    chk("rst_flushcnt", 32'(FlushCount), 0);
    do_reset();

    // load-use on Rs2
    set_lw(5'd5, 5'd5, 1'b1);
    #1 chk("lw_stall", 32'(ctl()), 32'(C_LWS));
    tick();
    MemReadE = 0;
    #1 chk("lw_release", 32'(ctl()), 32'(C_IDLE));
    chk("lw_stallcnt", 32'(StallCycles), 1);
    // load-use on Rs1
    idle_inputs();
    MemReadE = 1; RD_E = 5'd7; Rs1_D = 5'd7; UsesRs1D = 1;
    #1 chk("lw_rs1", 32'(ctl()), 32'(C_LWS));
    tick();
    idle_inputs();
    #1 chk("lw_stallcnt2", 32'(StallCycles), 2);

    // no-stall cases
    set_lw(5'd0, 5'd0, 1'b1);
    #1 chk("lw_rd0", 32'(ctl()), 32'(C_IDLE));
    set_lw(5'd5, 5'd5, 1'b0);
    #1 chk("lw_nouse", 32'(ctl()), 32'(C_IDLE));
    set_lw(5'd5, 5'd5, 1'b1);
    MemReadE = 0;
    #1 chk("lw_noload", 32'(ctl()), 32'(C_IDLE));

    // taken branch with simultaneous load-use, two extra flush cycles
    do_reset();
    set_lw(5'd5, 5'd5, 1'b1);
    PCSrcE = 1;
    #1 chk("br_flush", 32'(ctl()), 32'(C_BR));
    tick();
    PCSrcE = 0;
    #1 chk("br_hold1", 32'(ctl()), 32'(C_RDR));
    tick();
    #1 chk("br_hold2", 32'(ctl()), 32'(C_RDR));
    tick();
    #1 chk("br_back_run", 32'(ctl()), 32'(C_LWS));
    chk("br_flushcnt", 32'(FlushCount), 1);
    tick();
    idle_inputs();

    // memory wait with a branch held in EX, then a redirect interrupted by a wait
    do_reset();
    MemReqM = 1; MemReadyM = 0; PCSrcE = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("mw_stall", 32'(ctl()), 32'(C_MEMW));
      tick();
    end
    MemReadyM = 1;
    #1 chk("mw_ready_br", 32'(ctl()), 32'(C_BR));
    tick();
    chk("mw_stallcnt", 32'(StallCycles), 4);
    chk("mw_flushcnt", 32'(FlushCount), 1);
    PCSrcE = 0; MemReqM = 0;
    #1 chk("mw_rdr1", 32'(ctl()), 32'(C_RDR));
    tick();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 2; i++) begin
      #1 chk("mw_rdr_wait", 32'(ctl()), 32'(C_MEMW));
      tick();
    end
    MemReadyM = 1;
    #1 chk("mw_rdr_release", 32'(ctl()), 32'(C_IDLE));
    tick();
    MemReqM = 0;
    #1 chk("mw_rdr_resume", 32'(ctl()), 32'(C_RDR));
    tick();
    #1 chk("mw_rdr_done", 32'(ctl()), 32'(C_IDLE));
    chk("mw_stallcnt2", 32'(StallCycles), 6);

    // timeout and sticky error, then reset in the middle of a wait
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 7; i++) tick();
    chk("to_before", 32'(MemErr), 0);
    tick();
    chk("to_set", 32'(MemErr), 1);
    #1 chk("to_still_stall", 32'(ctl()), 32'(C_MEMW));
    MemReadyM = 1;
    tick();
    chk("to_sticky", 32'(MemErr), 1);
    MemReadyM = 0;
    tick();
    tick();
    rst = 1;
    #1;
    chk("rst_mid_ctl", 32'(ctl()), 32'(C_IDLE));
    chk("rst_mid_err", 32'(MemErr), 0);
    chk("rst_mid_stallcnt", 32'(StallCycles), 0);
    tick();
    idle_inputs();
    rst = 0;
    #1 chk("rst_mid_run", 32'(ctl()), 32'(C_IDLE));
    set_lw(5'd9, 5'd9, 1'b1);
    #1 chk("rst_mid_lw", 32'(ctl()), 32'(C_LWS));

    // stall counter saturation
    do_reset();
    MemReqM = 1; MemReadyM = 0;
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(StallCycles), 14);
    for (int i = 0; i < 5; i++) tick();
    chk("sat_15", 32'(StallCycles), 15);
    idle_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
